// File: rtl/ratio_to_fixed_point_if.sv
// Start/done bus of the ratio to split fixed-point converter.
// The master drives the request; the slave returns the result.
interface ratio_to_fixed_point_if #(
  parameter int NUM_W = 21,
  parameter int X_W   = 10,
  parameter int Y_W   = 18
);
  logic                    start;
  logic signed [NUM_W-1:0] num;
  logic signed [NUM_W-1:0] den;
  logic                    busy;
  logic                    done;
  logic signed [X_W-1:0]   fixed_X;
  logic [Y_W-1:0]          fixed_Y;
  logic                    neg;
  logic                    overflow;
  logic                    div_by_zero;

  modport master (
    output start, num, den,
    input  busy, done, fixed_X, fixed_Y,
    input  neg, overflow, div_by_zero
  );

  modport slave (
    input  start, num, den,
    output busy, done, fixed_X, fixed_Y,
    output neg, overflow, div_by_zero
  );
endinterface

// File: rtl/ratio_to_fixed_point.sv
// Sequential signed divider: num/den -> integer part plus
// a 5-decimal fraction, one restoring quotient bit per clock.
module ratio_to_fixed_point #(
  parameter int NUM_W   = 21,
  parameter int X_W     = 10,
  parameter int Y_W     = 18,
  parameter int SCALE   = 100000,
  parameter int SCALE_W = 17
) (
  input logic clock,
  input logic resetn,
  ratio_to_fixed_point_if.slave bus
);

  localparam int AW = NUM_W + SCALE_W;
  localparam int RW = NUM_W + 1;
  localparam int CW = $clog2(AW);

  localparam logic [X_W-1:0] XMAX =
    {1'b0, {(X_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE, INT, FRAC, FIN
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     a_q;
  logic [RW-1:0]     r_q;
  logic [NUM_W-1:0]  d_q;
  logic [NUM_W-1:0]  qi_q;
  logic              sign_q;
  logic              dz_q;
  logic              busy_q;
  logic              done_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              neg_q;
  logic              ovf_q;
  logic              dzo_q;

  logic [NUM_W-1:0]  num_abs;
  logic [NUM_W-1:0]  den_abs;
  logic [RW-1:0]     sh;
  logic              ge;
  logic [RW-1:0]     r_d;
  logic [AW-1:0]     a_d;
  logic [AW-1:0]     prod;
  logic [SCALE_W-1:0] qf;
  logic              big;
  logic [X_W-1:0]    xsat;

  always_comb begin
    num_abs = bus.num[NUM_W-1] ? -bus.num : bus.num;
    den_abs = bus.den[NUM_W-1] ? -bus.den : bus.den;
    sh      = {r_q[NUM_W-1:0], a_q[AW-1]};
    ge      = sh >= {1'b0, d_q};
    r_d     = ge ? sh - {1'b0, d_q} : sh;
    a_d     = {a_q[AW-2:0], ge};
    prod    = AW'(r_d) * AW'(SCALE);
    qf      = a_q[SCALE_W-1:0];
    big     = qi_q > NUM_W'(XMAX);
    xsat    = sign_q ? -XMAX : XMAX;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      qi_q    <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q    <= {num_abs, {SCALE_W{1'b0}}};
            r_q    <= '0;
            d_q    <= den_abs;
            sign_q <= bus.num[NUM_W-1] ^ bus.den[NUM_W-1];
            dz_q   <= (bus.den == '0);
            busy_q <= 1'b1;
            // den=0 takes one dummy FRAC step so done lands after E2
            if (bus.den == '0) begin
              state_q <= FRAC;
              cnt_q   <= '0;
            end else begin
              state_q <= INT;
              cnt_q   <= CW'(NUM_W - 1);
            end
          end
        end
        INT: begin
          r_q   <= r_d;
          a_q   <= a_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            qi_q    <= a_d[NUM_W-1:0];
            a_q     <= prod;
            r_q     <= '0;
            cnt_q   <= CW'(AW - 1);
            state_q <= FRAC;
          end
        end
        FRAC: begin
          r_q   <= r_d;
          a_q   <= a_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIN;
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dzo_q   <= dz_q;
          if (dz_q) begin
            x_q   <= xsat;
            y_q   <= Y_W'(SCALE - 1);
            neg_q <= sign_q;
            ovf_q <= 1'b0;
          end else if (big) begin
            x_q   <= xsat;
            y_q   <= Y_W'(SCALE - 1);
            neg_q <= sign_q;
            ovf_q <= 1'b1;
          end else begin
            x_q   <= sign_q ? -X_W'(qi_q) : X_W'(qi_q);
            y_q   <= Y_W'(qf);
            neg_q <= sign_q & ((qi_q != '0) | (qf != '0));
            ovf_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fixed_X     = x_q;
  assign bus.fixed_Y     = y_q;
  assign bus.neg         = neg_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dzo_q;

endmodule
